// File: rtl/sprite_compositor_pkg.sv
// Shared definitions for the sprite compositor.
// Holds the background tile ids, the RGB444 palette, the flash timing
// constants, the flash FSM state type, and the tile colour lookup.
package sprite_compositor_pkg;

    // Background tile ids as delivered on blockType
    localparam logic [2:0] TILE_FOREGROUND = 3'd1;
    localparam logic [2:0] TILE_HALF_SLAB  = 3'd2;
    localparam logic [2:0] TILE_DOOR       = 3'd3;

    // RGB444 palette
    localparam logic [11:0] RGB_BLACK      = 12'h000;
    localparam logic [11:0] RGB_FOREGROUND = 12'h00F;
    localparam logic [11:0] RGB_HALF_SLAB  = 12'h0F0;
    localparam logic [11:0] RGB_DOOR       = 12'h630;
    localparam logic [11:0] RGB_SKY        = 12'hFFF;

    // Flash timing: frames loaded on a request, and the counter bit that blanks the sprite
    localparam logic [5:0] FLASH_RELOAD   = 6'd47;
    localparam int         FLASH_HIDE_BIT = 2;

    typedef enum logic {
        IDLE     = 1'b0,
        FLASHING = 1'b1
    } flash_state_t;

    // Background colour for a tile; the half slab only fills the upper
    // 16 rows of each 32-row tile cell.
    function automatic logic [11:0] tile_color(input logic [2:0] tile, input logic upper_half);
        logic [11:0] color;
        case (tile)
            TILE_FOREGROUND: color = RGB_FOREGROUND;
            TILE_HALF_SLAB:  color = upper_half ? RGB_HALF_SLAB : RGB_SKY;
            TILE_DOOR:       color = RGB_DOOR;
            default:         color = RGB_SKY;
        endcase
        return color;
    endfunction

endpackage

// File: rtl/sprite_compositor_channel.sv
// One sprite channel: frame-start shadow registers for geometry, enable and
// anchor, the combinational on-sprite test for the current pixel, and the
// per-sprite flash FSM.
// Ports:
//   clk, resetN           pixel clock, async active-low reset
//   frameStart            shadow load strobe and flash frame tick
//   hCount, vCount        current pixel coordinate
//   pos_x, pos_y          live sprite position
//   size_w, size_h        live sprite size
//   enable, anchor_bottom live visibility and y-is-bottom-row flag
//   flash_req             start/retrigger flash pulse
//   zone                  pixel lies inside the (shadowed) sprite
//   hidden                sprite is currently blanked by flashing
module sprite_channel #(
    parameter int COORD_W = 10,
    parameter int SIZE_W  = 6
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               frameStart,
    input  logic [COORD_W-1:0] hCount,
    input  logic [COORD_W-1:0] vCount,
    input  logic [COORD_W-1:0] pos_x,
    input  logic [COORD_W-1:0] pos_y,
    input  logic [SIZE_W-1:0]  size_w,
    input  logic [SIZE_W-1:0]  size_h,
    input  logic               enable,
    input  logic               anchor_bottom,
    input  logic               flash_req,
    output logic               zone,
    output logic               hidden
);
    import sprite_compositor_pkg::*;

    // One extra bit so that x+w and v+h never wrap
    localparam int EXT_W = COORD_W + 1;

    logic [COORD_W-1:0] shadow_x;
    logic [COORD_W-1:0] shadow_y;
    logic [SIZE_W-1:0]  shadow_w;
    logic [SIZE_W-1:0]  shadow_h;
    logic               shadow_enable;
    logic               shadow_anchor;

    logic [EXT_W-1:0] h_ext;
    logic [EXT_W-1:0] v_ext;
    logic [EXT_W-1:0] x_ext;
    logic [EXT_W-1:0] y_ext;
    logic [EXT_W-1:0] w_ext;
    logic [EXT_W-1:0] hgt_ext;
    logic             x_hit;
    logic             y_hit;

    flash_state_t flash_state;
    flash_state_t flash_state_next;
    logic [5:0]   flash_count;
    logic [5:0]   flash_count_next;

    // Geometry is only sampled at frame start so a frame renders consistently
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            shadow_x      <= '0;
            shadow_y      <= '0;
            shadow_w      <= '0;
            shadow_h      <= '0;
            shadow_enable <= 1'b0;
            shadow_anchor <= 1'b0;
        end else if (frameStart) begin
            shadow_x      <= pos_x;
            shadow_y      <= pos_y;
            shadow_w      <= size_w;
            shadow_h      <= size_h;
            shadow_enable <= enable;
            shadow_anchor <= anchor_bottom;
        end
    end

    assign h_ext   = EXT_W'(hCount);
    assign v_ext   = EXT_W'(vCount);
    assign x_ext   = EXT_W'(shadow_x);
    assign y_ext   = EXT_W'(shadow_y);
    assign w_ext   = EXT_W'(shadow_w);
    assign hgt_ext = EXT_W'(shadow_h);

    // Inclusive ranges rewritten as half-open compares: x <= h < x+w.
    // A bottom-anchored sprite spans y-h+1..y, i.e. v <= y and v+h > y,
    // which avoids a negative lower bound. Zero sizes yield empty ranges.
    always_comb begin
        x_hit = (h_ext >= x_ext) && (h_ext < x_ext + w_ext);
        if (shadow_anchor) begin
            y_hit = (v_ext <= y_ext) && (v_ext + hgt_ext > y_ext);
        end else begin
            y_hit = (v_ext >= y_ext) && (v_ext < y_ext + hgt_ext);
        end
        zone = shadow_enable && x_hit && y_hit;
    end

    // Flash FSM state register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            flash_state <= IDLE;
            flash_count <= '0;
        end else begin
            flash_state <= flash_state_next;
            flash_count <= flash_count_next;
        end
    end

    // A request always wins, including over the frame-start decrement.
    // The FSM leaves FLASHING on the frame start that finds the counter at 0.
    always_comb begin
        flash_state_next = flash_state;
        flash_count_next = flash_count;
        hidden           = 1'b0;
        case (flash_state)
            IDLE: begin
                if (flash_req) begin
                    flash_state_next = FLASHING;
                    flash_count_next = FLASH_RELOAD;
                end
            end
            FLASHING: begin
                hidden = flash_count[FLASH_HIDE_BIT];
                if (flash_req) begin
                    flash_count_next = FLASH_RELOAD;
                end else if (frameStart) begin
                    if (flash_count == 6'd0) begin
                        flash_state_next = IDLE;
                    end else begin
                        flash_count_next = flash_count - 6'd1;
                    end
                end
            end
            default: begin
                flash_state_next = IDLE;
                flash_count_next = '0;
            end
        endcase
    end

endmodule

// File: rtl/sprite_compositor.sv
// Sprite compositor: overlays up to NUM_SPRITES rectangular single-colour
// sprites (index 0 on top) on a tiled background, two-stage pipeline from
// pixel coordinate to registered rgb, and reports per-frame overlaps of
// sprite 0 with every other sprite.
// Ports:
//   clk, resetN          pixel clock, async active-low reset
//   frameStart           frame start pulse (shadow load, flash tick, hit report)
//   bright, hCount/vCount visible flag and pixel coordinate
//   spritePos/Size/Color packed per-sprite {x,y}, {w,h}, RGB444
//   spriteEnable/AnchorBottom/FlashReq  per-sprite control bits
//   blockType            background tile id for the current pixel
//   rgb                  registered output colour, 2 cycles after the pixel
//   hitMask              overlaps of sprite 0 with sprite i in the previous frame
module sprite_compositor #(
    parameter int NUM_SPRITES   = 6,
    parameter int COORD_W       = 10,
    parameter int SIZE_W        = 6,
    parameter int TILE_Y_OFFSET = 35
) (
    input  logic                            clk,
    input  logic                            resetN,
    input  logic                            frameStart,
    input  logic                            bright,
    input  logic [COORD_W-1:0]              hCount,
    input  logic [COORD_W-1:0]              vCount,
    input  logic [NUM_SPRITES*2*COORD_W-1:0] spritePos,
    input  logic [NUM_SPRITES*2*SIZE_W-1:0]  spriteSize,
    input  logic [NUM_SPRITES*12-1:0]        spriteColor,
    input  logic [NUM_SPRITES-1:0]           spriteEnable,
    input  logic [NUM_SPRITES-1:0]           spriteAnchorBottom,
    input  logic [NUM_SPRITES-1:0]           spriteFlashReq,
    input  logic [2:0]                       blockType,
    output logic [11:0]                      rgb,
    output logic [NUM_SPRITES-1:0]           hitMask
);
    import sprite_compositor_pkg::*;

    localparam logic [COORD_W-1:0] TILE_OFFSET_V = COORD_W'(TILE_Y_OFFSET);

    logic [NUM_SPRITES-1:0] zone_now;
    logic [NUM_SPRITES-1:0] hidden;
    logic [COORD_W-1:0]     tile_row;
    logic                   upper_half_now;

    logic [NUM_SPRITES-1:0] s1_zone;
    logic                   s1_bright;
    logic [2:0]             s1_tile;
    logic                   s1_upper_half;

    logic                   sprite_found;
    logic [11:0]            sprite_rgb;
    logic [11:0]            next_rgb;
    logic [NUM_SPRITES-1:0] overlap_now;
    logic [NUM_SPRITES-1:0] sticky;

    for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_channel
        sprite_channel #(
            .COORD_W (COORD_W),
            .SIZE_W  (SIZE_W)
        ) u_channel (
            .clk           (clk),
            .resetN        (resetN),
            .frameStart    (frameStart),
            .hCount        (hCount),
            .vCount        (vCount),
            .pos_x         (spritePos[i*2*COORD_W+COORD_W +: COORD_W]),
            .pos_y         (spritePos[i*2*COORD_W +: COORD_W]),
            .size_w        (spriteSize[i*2*SIZE_W+SIZE_W +: SIZE_W]),
            .size_h        (spriteSize[i*2*SIZE_W +: SIZE_W]),
            .enable        (spriteEnable[i]),
            .anchor_bottom (spriteAnchorBottom[i]),
            .flash_req     (spriteFlashReq[i]),
            .zone          (zone_now[i]),
            .hidden        (hidden[i])
        );
    end

    // Tile cells are 32 rows tall starting at TILE_Y_OFFSET; only the
    // row-within-cell matters, so modulo arithmetic on vCount is fine.
    assign tile_row       = (vCount - TILE_OFFSET_V) & COORD_W'(31);
    assign upper_half_now = (tile_row <= COORD_W'(15));

    // Stage 1: register zone hits and background context for the pixel
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            s1_zone       <= '0;
            s1_bright     <= 1'b0;
            s1_tile       <= '0;
            s1_upper_half <= 1'b0;
        end else begin
            s1_zone       <= zone_now;
            s1_bright     <= bright;
            s1_tile       <= blockType;
            s1_upper_half <= upper_half_now;
        end
    end

    // Priority pick: scanning from the top index down lets sprite 0 win.
    // Flash blanking only affects drawing, not overlap detection.
    always_comb begin
        sprite_found = 1'b0;
        sprite_rgb   = RGB_BLACK;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (s1_zone[i] && !hidden[i]) begin
                sprite_found = 1'b1;
                sprite_rgb   = spriteColor[i*12 +: 12];
            end
        end
        if (!s1_bright) begin
            next_rgb = RGB_BLACK;
        end else if (sprite_found) begin
            next_rgb = sprite_rgb;
        end else begin
            next_rgb = tile_color(s1_tile, s1_upper_half);
        end
    end

    // Stage 2: output colour register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rgb <= RGB_BLACK;
        end else begin
            rgb <= next_rgb;
        end
    end

    // Sprite 0 overlapping sprite i on a visible pixel; bit 0 is meaningless
    always_comb begin
        overlap_now = '0;
        if (s1_bright && s1_zone[0]) begin
            overlap_now = s1_zone;
        end
        overlap_now[0] = 1'b0;
    end

    // On frame start the finished frame is reported and a new one begins;
    // an overlap seen on that very cycle already belongs to the new frame.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            sticky  <= '0;
            hitMask <= '0;
        end else if (frameStart) begin
            hitMask <= sticky;
            sticky  <= overlap_now;
        end else begin
            sticky  <= sticky | overlap_now;
        end
    end

endmodule

// File: tb/tb_sprite_compositor.sv
// Self-checking bench for sprite_compositor: a constant vector table,
// hand-written frame sequences (priority, shadowing, flash, hits, reset),
// and randomized frames checked against a behavioural model.
module tb_sprite_compositor;

    localparam int NS = 6;
    localparam int CW = 10;
    localparam int SW = 6;

    logic                 clk;
    logic                 resetN;
    logic                 frameStart;
    logic                 bright;
    logic [CW-1:0]        hCount;
    logic [CW-1:0]        vCount;
    logic [NS*2*CW-1:0]   spritePos;
    logic [NS*2*SW-1:0]   spriteSize;
    logic [NS*12-1:0]     spriteColor;
    logic [NS-1:0]        spriteEnable;
    logic [NS-1:0]        spriteAnchorBottom;
    logic [NS-1:0]        spriteFlashReq;
    logic [2:0]           blockType;
    logic [11:0]          rgb;
    logic [NS-1:0]        hitMask;

    sprite_compositor #(
        .NUM_SPRITES   (NS),
        .COORD_W       (CW),
        .SIZE_W        (SW),
        .TILE_Y_OFFSET (35)
    ) dut (
        .clk                (clk),
        .resetN             (resetN),
        .frameStart         (frameStart),
        .bright             (bright),
        .hCount             (hCount),
        .vCount             (vCount),
        .spritePos          (spritePos),
        .spriteSize         (spriteSize),
        .spriteColor        (spriteColor),
        .spriteEnable       (spriteEnable),
        .spriteAnchorBottom (spriteAnchorBottom),
        .spriteFlashReq     (spriteFlashReq),
        .blockType          (blockType),
        .rgb                (rgb),
        .hitMask            (hitMask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Live sprite configuration driven onto the packed ports
    int          cfg_x[NS];
    int          cfg_y[NS];
    int          cfg_w[NS];
    int          cfg_h[NS];
    logic [11:0] cfg_color[NS];
    logic [NS-1:0] cfg_en;
    logic [NS-1:0] cfg_anchor;

    always_comb begin
        spritePos   = '0;
        spriteSize  = '0;
        spriteColor = '0;
        for (int i = 0; i < NS; i++) begin
            spritePos[i*2*CW +: 2*CW]  = {CW'(cfg_x[i]), CW'(cfg_y[i])};
            spriteSize[i*2*SW +: 2*SW] = {SW'(cfg_w[i]), SW'(cfg_h[i])};
            spriteColor[i*12 +: 12]    = cfg_color[i];
        end
    end
    assign spriteEnable       = cfg_en;
    assign spriteAnchorBottom = cfg_anchor;

    // Reference model state: per-frame snapshot, frames of flashing left
    // (-1 = not flashing), and the hit bookkeeping
    int          sh_x[NS];
    int          sh_y[NS];
    int          sh_w[NS];
    int          sh_h[NS];
    bit          sh_en[NS];
    bit          sh_anchor[NS];
    int          flash_left[NS];
    bit [NS-1:0] m_sticky;
    bit [NS-1:0] m_hit;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          h;
        int          v;
        bit          b;
        int          bt;
        logic [11:0] exp_rgb;
    } vec_t;

    vec_t vecs[14];

    function automatic bit m_zone(int i, int h, int v);
        if (!sh_en[i]) return 1'b0;
        if (h < sh_x[i] || h > sh_x[i] + sh_w[i] - 1) return 1'b0;
        if (sh_anchor[i]) return (v >= sh_y[i] - sh_h[i] + 1) && (v <= sh_y[i]);
        return (v >= sh_y[i]) && (v <= sh_y[i] + sh_h[i] - 1);
    endfunction

    function automatic bit m_hidden(int i);
        return (flash_left[i] >= 0) && (((flash_left[i] >> 2) & 1) == 1);
    endfunction

    function automatic logic [11:0] m_rgb(int h, int v, bit b, int bt);
        if (!b) return 12'h000;
        for (int i = 0; i < NS; i++) begin
            if (m_zone(i, h, v) && !m_hidden(i)) return cfg_color[i];
        end
        case (bt)
            1: return 12'h00F;
            2: return (((v - 35) & 31) <= 15) ? 12'h0F0 : 12'hFFF;
            3: return 12'h630;
            default: return 12'hFFF;
        endcase
    endfunction

    task automatic modelReset();
        for (int i = 0; i < NS; i++) begin
            sh_x[i] = 0; sh_y[i] = 0; sh_w[i] = 0; sh_h[i] = 0;
            sh_en[i] = 1'b0; sh_anchor[i] = 1'b0;
            flash_left[i] = -1;
        end
        m_sticky = '0;
        m_hit    = '0;
    endtask

    task automatic modelFrame(logic [NS-1:0] req);
        m_hit    = m_sticky;
        m_sticky = '0;
        for (int i = 0; i < NS; i++) begin
            sh_x[i] = cfg_x[i]; sh_y[i] = cfg_y[i];
            sh_w[i] = cfg_w[i]; sh_h[i] = cfg_h[i];
            sh_en[i] = cfg_en[i]; sh_anchor[i] = cfg_anchor[i];
            if (req[i]) flash_left[i] = 47;
            else if (flash_left[i] == 0) flash_left[i] = -1;
            else if (flash_left[i] > 0) flash_left[i] = flash_left[i] - 1;
        end
    endtask

    task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Present one pixel, check rgb two edges later, then idle one cycle so
    // the pixel has left stage 1 before anything else happens
    task automatic applyStimulus(int h, int v, bit b, int bt, logic [11:0] expected, string name);
        hCount    = CW'(h);
        vCount    = CW'(v);
        bright    = b;
        blockType = 3'(bt);
        if (b && m_zone(0, h, v)) begin
            for (int i = 1; i < NS; i++) if (m_zone(i, h, v)) m_sticky[i] = 1'b1;
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput(name, 32'(rgb), 32'(expected));
        bright = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic pulseFrame(logic [NS-1:0] req, string name);
        frameStart     = 1'b1;
        spriteFlashReq = req;
        modelFrame(req);
        @(posedge clk);
        #1;
        frameStart     = 1'b0;
        spriteFlashReq = '0;
        checkOutput(name, 32'(hitMask), 32'(m_hit));
    endtask

    task automatic requestFlash(logic [NS-1:0] mask);
        spriteFlashReq = mask;
        for (int i = 0; i < NS; i++) if (mask[i]) flash_left[i] = 47;
        @(posedge clk);
        #1;
        spriteFlashReq = '0;
    endtask

    task automatic clearConfig();
        for (int i = 0; i < NS; i++) begin
            cfg_x[i] = 0; cfg_y[i] = 0; cfg_w[i] = 0; cfg_h[i] = 0;
            cfg_color[i] = 12'h000;
        end
        cfg_en     = '0;
        cfg_anchor = '0;
    endtask

    initial begin
        resetN         = 1'b0;
        frameStart     = 1'b0;
        bright         = 1'b0;
        hCount         = '0;
        vCount         = '0;
        blockType      = '0;
        spriteFlashReq = '0;
        clearConfig();
        modelReset();

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_rgb", 32'(rgb), 32'h000);
        checkOutput("reset_hit", 32'(hitMask), 32'h0);
        resetN = 1'b1;
        @(posedge clk);
        #1;

        // ---- bottom-anchored sprite 0 and background tiles, constant table ----
        cfg_x[0] = 100; cfg_y[0] = 200; cfg_w[0] = 32; cfg_h[0] = 32;
        cfg_anchor[0] = 1'b1; cfg_en[0] = 1'b1; cfg_color[0] = 12'hABC;
        pulseFrame('0, "hit_table");
        vecs[0]  = '{100, 169, 1'b1, 0, 12'hABC};
        vecs[1]  = '{100, 168, 1'b1, 0, 12'hFFF};
        vecs[2]  = '{131, 200, 1'b1, 0, 12'hABC};
        vecs[3]  = '{132, 200, 1'b1, 0, 12'hFFF};
        vecs[4]  = '{ 99, 180, 1'b1, 0, 12'hFFF};
        vecs[5]  = '{100, 201, 1'b1, 0, 12'hFFF};
        vecs[6]  = '{100, 169, 1'b0, 0, 12'h000};
        vecs[7]  = '{ 10,  35, 1'b1, 2, 12'h0F0};
        vecs[8]  = '{ 10,  51, 1'b1, 2, 12'hFFF};
        vecs[9]  = '{ 10,  50, 1'b1, 2, 12'h0F0};
        vecs[10] = '{ 10,  34, 1'b1, 2, 12'hFFF};
        vecs[11] = '{ 10, 300, 1'b1, 1, 12'h00F};
        vecs[12] = '{ 10, 300, 1'b1, 3, 12'h630};
        vecs[13] = '{100, 185, 1'b1, 1, 12'hABC};
        for (int k = 0; k < 14; k++) begin
            applyStimulus(vecs[k].h, vecs[k].v, vecs[k].b, vecs[k].bt, vecs[k].exp_rgb,
                          $sformatf("vec%0d", k));
        end

        // ---- priority, disable at frame start, mid-frame shadowing ----
        clearConfig();
        cfg_x[0] = 40; cfg_y[0] = 40; cfg_w[0] = 20; cfg_h[0] = 20; cfg_color[0] = 12'hF00;
        cfg_x[1] = 45; cfg_y[1] = 45; cfg_w[1] = 10; cfg_h[1] = 10; cfg_color[1] = 12'h6DF;
        cfg_en = 6'b000011;
        pulseFrame('0, "hit_prio0");
        applyStimulus(50, 50, 1'b1, 0, 12'hF00, "prio_s0");
        cfg_en[0] = 1'b0;
        pulseFrame('0, "hit_prio1");
        checkOutput("hit_prio_const", 32'(hitMask), 32'h02);
        applyStimulus(50, 50, 1'b1, 0, 12'h6DF, "prio_s1");
        cfg_x[1] = 200;
        applyStimulus(50, 50, 1'b1, 0, 12'h6DF, "shadow_hold");
        pulseFrame('0, "hit_shadow");
        applyStimulus(50, 50, 1'b1, 0, 12'hFFF, "shadow_moved_old");
        applyStimulus(205, 50, 1'b1, 0, 12'h6DF, "shadow_moved_new");

        // ---- hit reporting across frames ----
        clearConfig();
        cfg_x[0] = 300; cfg_y[0] = 100; cfg_w[0] = 16; cfg_h[0] = 16; cfg_color[0] = 12'h123;
        cfg_x[3] = 310; cfg_y[3] = 105; cfg_w[3] = 16; cfg_h[3] = 16; cfg_color[3] = 12'h456;
        cfg_en = 6'b001001;
        pulseFrame('0, "hit_n");
        applyStimulus(312, 108, 1'b1, 0, 12'h123, "hit_overlap_px");
        pulseFrame('0, "hit_n1");
        checkOutput("hit_n1_const", 32'(hitMask), 32'h08);
        applyStimulus(302, 101, 1'b1, 0, 12'h123, "hit_single_px");
        pulseFrame('0, "hit_n2");
        checkOutput("hit_n2_const", 32'(hitMask), 32'h00);

        // overlap on the frame-start cycle belongs to the new frame
        hCount = CW'(312); vCount = CW'(108); bright = 1'b1; blockType = 3'd0;
        @(posedge clk);
        #1;
        bright     = 1'b0;
        frameStart = 1'b1;
        modelFrame('0);
        m_sticky[3] = 1'b1;
        @(posedge clk);
        #1;
        frameStart = 1'b0;
        checkOutput("hit_edge_old", 32'(hitMask), 32'h00);
        @(posedge clk);
        #1;
        pulseFrame('0, "hit_edge_new");
        checkOutput("hit_edge_new_const", 32'(hitMask), 32'h08);

        // ---- asynchronous reset mid-frame ----
        applyStimulus(312, 108, 1'b1, 0, 12'h123, "pre_reset_px");
        checkOutput("pre_reset_rgb", 32'(rgb), 32'h123);
        #2;
        resetN = 1'b0;
        #1;
        checkOutput("async_reset_rgb", 32'(rgb), 32'h000);
        checkOutput("async_reset_hit", 32'(hitMask), 32'h0);
        modelReset();
        @(posedge clk);
        #1;
        resetN = 1'b1;
        applyStimulus(302, 101, 1'b1, 0, 12'hFFF, "post_reset_hidden");
        pulseFrame('0, "hit_post_reset");
        applyStimulus(302, 101, 1'b1, 0, 12'h123, "post_reset_visible");

        // ---- flashing with a retrigger at counter 10 ----
        clearConfig();
        cfg_x[0] = 100; cfg_y[0] = 100; cfg_w[0] = 8; cfg_h[0] = 8; cfg_color[0] = 12'h0F8;
        cfg_en = 6'b000001;
        pulseFrame('0, "hit_flash_setup");
        requestFlash(6'b000001);
        applyStimulus(102, 102, 1'b1, 0, 12'hFFF, "flash_start_hidden");
        begin
            bit retriggered = 1'b0;
            for (int f = 0; f < 100; f++) begin
                if (!retriggered && flash_left[0] == 10) begin
                    requestFlash(6'b000001);
                    retriggered = 1'b1;
                end
                pulseFrame('0, "hit_flash");
                applyStimulus(102, 102, 1'b1, 0, m_rgb(102, 102, 1'b1, 0),
                              $sformatf("flash_f%0d", f));
            end
            checkOutput("flash_retriggered", 32'(retriggered), 32'h1);
        end
        applyStimulus(102, 102, 1'b1, 0, 12'h0F8, "flash_done_visible");

        // ---- randomized frames against the model ----
        for (int fr = 0; fr < 40; fr++) begin
            logic [NS-1:0] req;
            for (int i = 0; i < NS; i++) begin
                cfg_x[i]      = $urandom_range(0, 60);
                cfg_y[i]      = $urandom_range(0, 60);
                cfg_w[i]      = $urandom_range(0, 20);
                cfg_h[i]      = $urandom_range(0, 20);
                cfg_anchor[i] = 1'($urandom % 2);
                cfg_en[i]     = ($urandom % 4) != 0;
                cfg_color[i]  = 12'($urandom);
                req[i]        = ($urandom % 8) == 0;
            end
            pulseFrame(req, "rand_hit");
            if ($urandom % 4 == 0) requestFlash(NS'($urandom));
            for (int p = 0; p < 16; p++) begin
                int h  = $urandom_range(0, 80);
                int v  = $urandom_range(0, 80);
                bit b  = ($urandom % 5) != 0;
                int bt = $urandom_range(0, 7);
                if (p == 8) begin
                    for (int i = 0; i < NS; i++) cfg_x[i] = $urandom_range(0, 60);
                end
                applyStimulus(h, v, b, bt, m_rgb(h, v, b, bt), $sformatf("rand_f%0d_p%0d", fr, p));
            end
        end
        pulseFrame('0, "rand_hit_final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
